// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Eight 8-bit registers with two combinational read ports and
//               one write port. A write is either a single byte, or a 16-bit
//               pair whose low byte goes to R[rd] on the first edge and whose
//               high byte goes to R[(rd+1) mod 8] on the next edge.
//               Requests that arrive while the high byte is pending are
//               dropped.
//
// Ports       : clk          - system clock, rising edge active
//               reset        - asynchronous active-high reset
//               r_w_reg      - write strobe; only logic 0 requests a write
//               rd           - destination register index
//               rd_data      - write data, [7:0] low byte, [15:8] high byte
//               input_length - 0 = byte write, 1 = pair write
//               rs1, rs2     - read indices
//               rs1_data     - read data for rs1
//               rs2_data     - read data for rs2
//               busy         - high while the high byte is pending
//               wr_done      - one-cycle pulse when a write completes
//
// Options     : REGFILE_BYPASS_EN - when defined, reads forward the byte that
//               is being written at the next edge (read-after-write bypass).
//
// Revision    : 1.0 - initial release
// ============================================================================

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        r_w_reg,
  input  logic [2:0]  rd,
  input  logic [15:0] rd_data,
  input  logic        input_length,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  output logic [7:0]  rs1_data,
  output logic [7:0]  rs2_data,
  output logic        busy,
  output logic        wr_done
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_WR_HI = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  logic [7:0] r_regs [8];
  logic [7:0] r_hi_data;
  logic [2:0] r_hi_idx;
  logic       r_wr_done;

  logic       w_wr_lo;     // low byte (or single byte) written at this edge
  logic       w_wr_hi;     // pending high byte written at this edge
  logic       w_done_nxt;  // a write completes at this edge

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_wr_lo && input_length) begin
          w_state_nxt = c_WR_HI;
        end
      end
      c_WR_HI: begin
        // Any request seen here is dropped, never queued.
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode. Written with if-statements so that a strobe of
  // z or x falls into the no-write branch instead of propagating unknowns.
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    w_wr_lo    = 1'b0;
    w_wr_hi    = 1'b0;
    w_done_nxt = 1'b0;
    if (r_state == c_WR_HI) begin
      busy       = 1'b1;
      w_wr_hi    = 1'b1;
      w_done_nxt = 1'b1;
    end else if (r_w_reg == 1'b0) begin
      w_wr_lo = 1'b1;
      if (input_length == 1'b0) begin
        w_done_nxt = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register array, pending high byte and completion pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_hi_data <= 8'h00;
      r_hi_idx  <= 3'd0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_done_nxt;
      if (w_wr_lo) begin
        r_regs[rd] <= rd_data[7:0];
        // Latched on every accepted request; only consumed for pair writes.
        // The 3-bit add wraps R7 onto R0.
        r_hi_data  <= rd_data[15:8];
        r_hi_idx   <= rd + 3'd1;
      end
      if (w_wr_hi) begin
        r_regs[r_hi_idx] <= r_hi_data;
      end
    end
  end

  assign wr_done = r_wr_done;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs1_data = r_regs[rs1];
    if (w_wr_lo && (rs1 == rd)) begin
      rs1_data = rd_data[7:0];
    end else if (w_wr_hi && (rs1 == r_hi_idx)) begin
      rs1_data = r_hi_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[rs2];
    if (w_wr_lo && (rs2 == rd)) begin
      rs2_data = rd_data[7:0];
    end else if (w_wr_hi && (rs2 == r_hi_idx)) begin
      rs2_data = r_hi_data;
    end
  end
`else
  assign rs1_data = r_regs[rs1];
  assign rs2_data = r_regs[rs2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Directed scenarios plus a
//               randomized run compared against a behavioural model (an
//               array of eight bytes and an optional pending high byte).
//               Honours REGFILE_BYPASS_EN for the expected read values.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_w_reg;
  logic [2:0]  rd;
  logic [15:0] rd_data;
  logic        input_length;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [7:0]  rs1_data;
  logic [7:0]  rs2_data;
  logic        busy;
  logic        wr_done;

  reg_file dut (
    .clk          (clk),
    .reset        (reset),
    .r_w_reg      (r_w_reg),
    .rd           (rd),
    .rd_data      (rd_data),
    .input_length (input_length),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .busy         (busy),
    .wr_done      (wr_done)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0] model [8];
  logic       pend;
  logic [2:0] pend_idx;
  logic [7:0] pend_byte;

  int n_tests = 0;
  int n_fail  = 0;

  // Value the read port should show right now, given model state and inputs.
  function automatic logic [7:0] exp_read(input logic [2:0] idx);
    logic [7:0] v;
    v = model[idx];
`ifdef REGFILE_BYPASS_EN
    if (pend) begin
      if (idx == pend_idx) v = pend_byte;
    end else if ((r_w_reg === 1'b0) && (idx == rd)) begin
      v = rd_data[7:0];
    end
`endif
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; r_w_reg = 1'b0; rd = 3'd2; rd_data = 16'hFFFF;
    input_length = 1'b0; rs1 = 3'd0; rs2 = 3'd0;
    pend = 1'b0; pend_idx = 3'd0; pend_byte = 8'h00;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    // Write requests are driven while reset is high; none may land.
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
    r_w_reg = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); rs2 = 3'(7 - i); #1;
      n_tests++; if (rs1_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg R%0d got=%h exp=00", i, rs1_data); end
      n_tests++; if (rs2_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg2 R%0d got=%h exp=00", 7 - i, rs2_data); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd3; rd_data = 16'h00A5; input_length = 1'b0; rs1 = 3'd3;
    @(posedge clk); #1;
    model[3] = 8'hA5;
    n_tests++; if (rs1_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", rs1_data); end
    n_tests++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b exp=1", wr_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", busy); end
    r_w_reg = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got=%b exp=0", wr_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy2 got=%b exp=0", busy); end
  endtask

  task automatic test_pair_wrap();
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd7; rd_data = 16'h1234; input_length = 1'b1; rs1 = 3'd7; rs2 = 3'd0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pair_busy got=%b exp=1", busy); end
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL pair_done_early got=%b exp=0", wr_done); end
    n_tests++; if (rs1_data !== 8'h34) begin n_fail++; $display("FAIL pair_lo R7 got=%h exp=34", rs1_data); end
`ifdef REGFILE_BYPASS_EN
    n_tests++; if (rs2_data !== 8'h12) begin n_fail++; $display("FAIL pair_hi_bypass R0 got=%h exp=12", rs2_data); end
`else
    n_tests++; if (rs2_data !== 8'h00) begin n_fail++; $display("FAIL pair_hi_early R0 got=%h exp=00", rs2_data); end
`endif
    r_w_reg = 1'b1;
    @(posedge clk); #1;
    model[7] = 8'h34; model[0] = 8'h12;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pair_busy_end got=%b exp=0", busy); end
    n_tests++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL pair_done got=%b exp=1", wr_done); end
    n_tests++; if (rs2_data !== 8'h12) begin n_fail++; $display("FAIL pair_hi R0 got=%h exp=12", rs2_data); end
    @(posedge clk); #1;
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL pair_done_pulse got=%b exp=0", wr_done); end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); #1;
      n_tests++; if (rs1_data !== model[i]) begin n_fail++; $display("FAIL pair_scan R%0d got=%h exp=%h", i, rs1_data, model[i]); end
    end
  endtask

  task automatic test_ignore_in_wr_hi();
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd2; rd_data = 16'h5A3C; input_length = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd5; rd_data = 16'h0077; input_length = 1'b0;
    @(posedge clk); #1;
    r_w_reg = 1'b1;
    model[2] = 8'h3C; model[3] = 8'h5A;
    n_tests++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got=%b exp=1", wr_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL ignore_no_extra_done got=%b exp=0", wr_done); end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); #1;
      n_tests++; if (rs1_data !== model[i]) begin n_fail++; $display("FAIL ignore_scan R%0d got=%h exp=%h", i, rs1_data, model[i]); end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd4; rd_data = 16'hBEEF; input_length = 1'b1;
    @(posedge clk); #2;
    r_w_reg = 1'b1;
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", wr_done); end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy2 got=%b exp=0", busy); end
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL abort_done2 got=%b exp=0", wr_done); end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); #1;
      n_tests++; if (rs1_data !== 8'h00) begin n_fail++; $display("FAIL abort_scan R%0d got=%h exp=00", i, rs1_data); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    r_w_reg = 1'b0; rd = 3'd1; rd_data = 16'h00C3; input_length = 1'b0; rs2 = 3'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_tests++; if (rs2_data !== 8'hC3) begin n_fail++; $display("FAIL bypass_same_cycle got=%h exp=c3", rs2_data); end
`else
    n_tests++; if (rs2_data !== 8'h00) begin n_fail++; $display("FAIL no_bypass_same_cycle got=%h exp=00", rs2_data); end
`endif
    @(posedge clk); #1;
    r_w_reg = 1'b1;
    model[1] = 8'hC3;
    #1;
    n_tests++; if (rs2_data !== 8'hC3) begin n_fail++; $display("FAIL bypass_after_edge got=%h exp=c3", rs2_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d = 8'($urandom);
      r_w_reg = 1'b0; rd = 3'(4 + k); rd_data = {8'($urandom), d}; input_length = 1'b0; rs1 = 3'(4 + k);
      @(posedge clk); #1;
      model[4 + k] = d;
      n_tests++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b exp=1", k, wr_done); end
      n_tests++; if (rs1_data !== d) begin n_fail++; $display("FAIL b2b_data R%0d got=%h exp=%h", 4 + k, rs1_data, d); end
    end
    r_w_reg = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end got=%b exp=0", wr_done); end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); #1;
      n_tests++; if (rs1_data !== model[i]) begin n_fail++; $display("FAIL b2b_scan R%0d got=%h exp=%h", i, rs1_data, model[i]); end
    end
  endtask

  // Strobe held inactive with the other write inputs toggling randomly.
  task automatic test_no_write();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r_w_reg = 1'b1; rd = 3'($urandom); rd_data = 16'($urandom); input_length = 1'($urandom);
      @(posedge clk); #1;
      n_tests++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL nowr_done k=%0d got=%b exp=0", k, wr_done); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nowr_busy got=%b exp=0", busy); end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i); #1;
      n_tests++; if (rs1_data !== model[i]) begin n_fail++; $display("FAIL nowr_scan R%0d got=%h exp=%h", i, rs1_data, model[i]); end
    end
  endtask

  task automatic test_random();
    logic exp_done;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      r_w_reg      = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
      rd           = 3'($urandom);
      rd_data      = 16'($urandom);
      input_length = 1'($urandom);
      rs1          = 3'($urandom);
      rs2          = 3'($urandom);
      #1;
      n_tests++; if (rs1_data !== exp_read(rs1)) begin n_fail++; $display("FAIL rnd_pre_rs1 cyc=%0d got=%h exp=%h", cyc, rs1_data, exp_read(rs1)); end
      n_tests++; if (rs2_data !== exp_read(rs2)) begin n_fail++; $display("FAIL rnd_pre_rs2 cyc=%0d got=%h exp=%h", cyc, rs2_data, exp_read(rs2)); end
      // Effect of the coming edge.
      exp_done = 1'b0;
      if (pend) begin
        model[pend_idx] = pend_byte;
        pend = 1'b0;
        exp_done = 1'b1;
      end else if (r_w_reg == 1'b0) begin
        model[rd] = rd_data[7:0];
        if (input_length) begin
          pend = 1'b1;
          pend_idx = 3'((int'(rd) + 1) % 8);
          pend_byte = rd_data[15:8];
        end else begin
          exp_done = 1'b1;
        end
      end
      @(posedge clk); #1;
      n_tests++; if (busy !== pend) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, pend); end
      n_tests++; if (wr_done !== exp_done) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, wr_done, exp_done); end
      n_tests++; if (rs1_data !== exp_read(rs1)) begin n_fail++; $display("FAIL rnd_post_rs1 cyc=%0d got=%h exp=%h", cyc, rs1_data, exp_read(rs1)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_pair_wrap();
    test_ignore_in_wr_hi();
    test_reset_abort();
    test_bypass();
    test_back_to_back();
    test_no_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
